// File: rtl/n64_console_responder_if.sv
// Console-side signal bundle for the N64 Joybus responder: the open-drain
// data line pair, the controller word to serve, and the status outputs.
interface n64_console_responder_if;
  logic        console_d_in;
  logic        console_d_oe;
  logic [31:0] controller_data;
  logic        busy;
  logic        poll_served;
  logic [7:0]  last_cmd;

  // Drives the line and the controller word, observes the responder.
  modport master (
    output console_d_in,
    output controller_data,
    input  console_d_oe,
    input  busy,
    input  poll_served,
    input  last_cmd
  );

  // The responder itself.
  modport slave (
    input  console_d_in,
    input  controller_data,
    output console_d_oe,
    output busy,
    output poll_served,
    output last_cmd
  );
endinterface

// File: rtl/n64_console_responder.sv
// N64 Joybus controller-side responder. Decodes an 8-bit console command
// from the open-drain data line and answers poll (0x01) with the latest
// controller word, or identity (0x00 / 0xFF) with 0x050002. The line is
// only ever pulled low or released.
module n64_console_responder #(
  parameter int CYC_US     = 50,
  parameter int SAMPLE_AT  = 100,
  parameter int TURNAROUND = 100,
  parameter int RX_TIMEOUT = 300
) (
  input logic                     sys_clk,
  input logic                     reset,
  n64_console_responder_if.slave  bus
);

  localparam logic [8:0] L_SAMPLE   = 9'(SAMPLE_AT);
  localparam logic [8:0] L_TIMEOUT  = 9'(RX_TIMEOUT);
  localparam logic [8:0] L_TURN_END = 9'(TURNAROUND - 1);
  localparam logic [8:0] L_BIT_END  = 9'(4 * CYC_US - 1);
  localparam logic [8:0] L_ONE_LOW  = 9'(CYC_US);
  localparam logic [8:0] L_ZERO_LOW = 9'(3 * CYC_US);
  localparam logic [8:0] L_STOP_LOW = 9'(2 * CYC_US);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_BIT, S_RX_STOP, S_TURN, S_TX_BIT, S_TX_STOP, S_ABORT
  } state_t;

  state_t      r_state, w_state_n;
  logic [8:0]  r_cnt, w_cnt_n;
  logic [5:0]  r_bit, w_bit_n;
  logic [5:0]  r_len, w_len_n;
  logic        r_stop_low, w_stop_low_n;
  logic        r_is_poll, w_is_poll_n;
  logic        r_oe, w_oe_n;
  logic        r_busy;
  logic        r_served, w_served_n;
  logic [7:0]  r_last_cmd, w_last_cmd_n;
  logic [7:0]  r_rx, w_rx_n;
  logic [31:0] r_tx, w_tx_n;
  logic        r_sync1, r_sync2, r_prev;
  logic        w_fall, w_rise;

  // Edges are taken on the synchronised line; they lag the pad by two cycles.
  assign w_fall = r_prev & ~r_sync2;
  assign w_rise = ~r_prev & r_sync2;

  assign bus.console_d_oe = r_oe;
  assign bus.busy         = r_busy;
  assign bus.poll_served  = r_served;
  assign bus.last_cmd     = r_last_cmd;

  // Synchronise the console line; idle level is high so reset to 1.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= bus.console_d_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Control state register; reset releases the line at once.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_len      <= '0;
      r_stop_low <= 1'b0;
      r_is_poll  <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_served   <= 1'b0;
      r_last_cmd <= 8'h00;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_bit      <= w_bit_n;
      r_len      <= w_len_n;
      r_stop_low <= w_stop_low_n;
      r_is_poll  <= w_is_poll_n;
      r_oe       <= w_oe_n;
      r_busy     <= (w_state_n != S_IDLE);
      r_served   <= w_served_n;
      r_last_cmd <= w_last_cmd_n;
    end
  end

  // Receive and transmit shift registers carry data only, no reset needed.
  always_ff @(posedge sys_clk) begin
    r_rx <= w_rx_n;
    r_tx <= w_tx_n;
  end

  // Next-state, counters, shift registers and the line drive.
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt + 9'd1;
    w_bit_n      = r_bit;
    w_len_n      = r_len;
    w_stop_low_n = r_stop_low;
    w_is_poll_n  = r_is_poll;
    w_served_n   = 1'b0;
    w_last_cmd_n = r_last_cmd;
    w_rx_n       = r_rx;
    w_tx_n       = r_tx;
    w_oe_n       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        w_bit_n = '0;
        if (w_fall) w_state_n = S_RX_BIT;
      end
      S_RX_BIT: begin
        if (w_fall) begin
          w_cnt_n = '0;
        end else if (r_cnt == L_TIMEOUT) begin
          w_state_n = S_ABORT;
          w_cnt_n   = '0;
        end else if (r_cnt == L_SAMPLE) begin
          w_rx_n  = {r_rx[6:0], r_sync2};
          w_bit_n = r_bit + 6'd1;
          if (r_bit == 6'd7) begin
            w_state_n    = S_RX_STOP;
            w_stop_low_n = 1'b0;
          end
        end
      end
      S_RX_STOP: begin
        // A '0' last bit produces a rising edge before the stop bit, so the
        // command only completes on a rise that follows the stop-bit fall.
        if (w_fall) begin
          w_cnt_n      = '0;
          w_stop_low_n = 1'b1;
        end else if (r_stop_low && w_rise) begin
          w_last_cmd_n = r_rx;
          w_cnt_n      = '0;
          w_bit_n      = '0;
          case (r_rx)
            8'h01: begin
              w_tx_n      = bus.controller_data;
              w_len_n     = 6'd32;
              w_is_poll_n = 1'b1;
              w_state_n   = S_TURN;
            end
            8'h00, 8'hFF: begin
              w_tx_n      = {24'h050002, 8'h00};
              w_len_n     = 6'd24;
              w_is_poll_n = 1'b0;
              w_state_n   = S_TURN;
            end
            default: w_state_n = S_ABORT;
          endcase
        end else if (r_cnt == L_TIMEOUT) begin
          w_state_n = S_ABORT;
          w_cnt_n   = '0;
        end
      end
      S_TURN: begin
        if (w_fall) begin
          w_state_n = S_ABORT;
          w_cnt_n   = '0;
        end else if (r_cnt == L_TURN_END) begin
          w_state_n = S_TX_BIT;
          w_cnt_n   = '0;
        end
      end
      S_TX_BIT: begin
        if (r_cnt == L_BIT_END) begin
          w_cnt_n = '0;
          w_tx_n  = {r_tx[30:0], 1'b0};
          w_bit_n = r_bit + 6'd1;
          if (r_bit + 6'd1 == r_len) w_state_n = S_TX_STOP;
        end
      end
      S_TX_STOP: begin
        if (r_cnt == L_STOP_LOW) begin
          w_state_n  = S_IDLE;
          w_cnt_n    = '0;
          w_served_n = r_is_poll;
        end
      end
      S_ABORT: begin
        if (!r_sync2) begin
          w_cnt_n = '0;
        end else if (r_cnt == L_TIMEOUT) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_state_n == S_TX_BIT)
      w_oe_n = (w_cnt_n < (w_tx_n[31] ? L_ONE_LOW : L_ZERO_LOW));
    else if (w_state_n == S_TX_STOP)
      w_oe_n = (w_cnt_n < L_STOP_LOW);
  end

endmodule
